// File: rtl/nonce_search_engine.sv
// nonce_search_engine
//   Nonce-search controller for one processing element. Accepts an 80-byte
//   block header job, pads it into two 512-bit SHA256 blocks with the nonce
//   spliced into the low NONCE_W header bits, and drives an external SHA256
//   core through SHA256(SHA256(header||nonce)). The nonce is stepped by a
//   runtime stride until the digest has the requested number of leading zero
//   bits, the nonce range is used up, or the job is aborted.
//
//   Optional feature macro: NSE_HASH_CNT_EN
//     defined   : hash_cnt is a 64-bit saturating count of completed
//                 double-hash attempts, cleared when a job is accepted.
//     undefined : no counter; hash_cnt is tied to zero.
//
// Ports
//   CLK, nreset                 clock (rising edge), async active-low reset
//   job_valid / job_ready       job handshake; ready only while idle
//   job_header                  640-bit header (low NONCE_W bits replaced)
//   job_nonce_lo / job_nonce_hi first / last (inclusive) nonce of the range
//   job_stride                  nonce increment, 0 behaves as 1
//   job_zero_bits               required leading zero bits, clamped to 256
//   abort                       cancel the running job
//   sha_start / sha_msg /       one-cycle start pulse, message block and
//   sha_blk_type                block type (00 HASH, 10 HEADER) to the core
//   sha_hash / sha_blk_done     digest and completion pulse from the core
//   busy                        searching (not idle, no result pending)
//   result_valid/found/nonce/   result held until result_ack
//   result_hash, result_ack
//   hash_cnt                    completed attempts in the current job
module nonce_search_engine #(
  parameter int NONCE_W  = 32,
  parameter int STRIDE_W = 8,
  parameter int ZB_W     = 9
) (
  input  logic                CLK,
  input  logic                nreset,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [639:0]        job_header,
  input  logic [NONCE_W-1:0]  job_nonce_lo,
  input  logic [NONCE_W-1:0]  job_nonce_hi,
  input  logic [STRIDE_W-1:0] job_stride,
  input  logic [ZB_W-1:0]     job_zero_bits,
  input  logic                abort,
  output logic                sha_start,
  output logic [511:0]        sha_msg,
  output logic [1:0]          sha_blk_type,
  input  logic [255:0]        sha_hash,
  input  logic                sha_blk_done,
  output logic                busy,
  output logic                result_valid,
  output logic                result_found,
  output logic [NONCE_W-1:0]  result_nonce,
  output logic [255:0]        result_hash,
  input  logic                result_ack,
  output logic [63:0]         hash_cnt
);

  localparam logic [1:0] BT_HASH   = 2'b00;
  localparam logic [1:0] BT_HEADER = 2'b10;
  localparam logic [1:0] BT_IDLE   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PAD,
    S_BLK0,
    S_WAIT0,
    S_WAIT1,
    S_WAIT2,
    S_CHECK,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t state, state_next;

  // Job context and working buffers (datapath, not reset)
  logic [639:NONCE_W]  hdr_hi;
  logic [NONCE_W-1:0]  nonce;
  logic [NONCE_W-1:0]  nonce_hi;
  logic [STRIDE_W-1:0] stride;
  logic [8:0]          zero_bits;
  logic [1023:0]       msg_buf;
  logic [255:0]        digest;

  logic                accept;
  logic                start_next;
  logic                to_result;
  logic                res_found;
  logic                res_abort;
  logic [NONCE_W:0]    next_nonce;
  logic                exhausted;
  logic                hit;

  // The nonce field of the header is always overwritten.
  logic unused_hdr_nonce_bits;
  assign unused_hdr_nonce_bits = ^job_header[NONCE_W-1:0];

  function automatic logic [8:0] clamp_zero_bits(input logic [ZB_W-1:0] z);
    if (32'(z) > 32'd256) return 9'd256;
    return 9'(z);
  endfunction

  function automatic logic [STRIDE_W-1:0] fix_stride(input logic [STRIDE_W-1:0] s);
    return (s == '0) ? STRIDE_W'(1) : s;
  endfunction

  // Top zb bits of the digest must be zero; a shift of 256 yields an
  // all-ones mask, zb = 0 yields an empty mask (always a hit).
  function automatic logic leading_zeros_ok(input logic [255:0] d,
                                            input logic [8:0]   zb);
    logic [255:0] mask;
    mask = ~({256{1'b1}} >> zb);
    return (d & mask) == '0;
  endfunction

  // One extra bit catches wrap-around past the top of the nonce space.
  assign next_nonce = {1'b0, nonce} + (NONCE_W+1)'(stride);
  assign exhausted  = next_nonce[NONCE_W] | (next_nonce[NONCE_W-1:0] > nonce_hi);
  assign hit        = leading_zeros_ok(digest, zero_bits);

  assign job_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE) && (state != S_RESULT);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    start_next = 1'b0;
    to_result  = 1'b0;
    res_found  = 1'b0;
    res_abort  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (job_valid) begin
          accept     = 1'b1;
          state_next = S_PAD;
        end
      end
      S_PAD, S_BLK0: begin
        if (abort) begin
          to_result  = 1'b1;
          res_abort  = 1'b1;
          state_next = S_RESULT;
        end else if (state == S_PAD) begin
          state_next = S_BLK0;
        end else begin
          start_next = 1'b1;
          state_next = S_WAIT0;
        end
      end
      S_WAIT0, S_WAIT1, S_WAIT2: begin
        if (abort) begin
          // A completion arriving with the abort leaves nothing to drain.
          if (sha_blk_done) begin
            to_result  = 1'b1;
            res_abort  = 1'b1;
            state_next = S_RESULT;
          end else begin
            state_next = S_DRAIN;
          end
        end else if (sha_blk_done) begin
          if (state == S_WAIT2) begin
            state_next = S_CHECK;
          end else begin
            start_next = 1'b1;
            state_next = (state == S_WAIT0) ? S_WAIT1 : S_WAIT2;
          end
        end
      end
      S_CHECK: begin
        if (hit) begin
          to_result  = 1'b1;
          res_found  = 1'b1;
          state_next = S_RESULT;
        end else if (abort || exhausted) begin
          to_result  = 1'b1;
          state_next = S_RESULT;
        end else begin
          state_next = S_PAD;
        end
      end
      S_DRAIN: begin
        if (sha_blk_done) begin
          to_result  = 1'b1;
          res_abort  = 1'b1;
          state_next = S_RESULT;
        end
      end
      S_RESULT: begin
        if (result_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control and core-facing outputs
  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      state        <= S_IDLE;
      sha_start    <= 1'b0;
      sha_msg      <= '0;
      sha_blk_type <= BT_IDLE;
      result_valid <= 1'b0;
      result_found <= 1'b0;
      result_nonce <= '0;
      result_hash  <= '0;
    end else begin
      state     <= state_next;
      sha_start <= start_next;
      if (state == S_PAD) sha_blk_type <= BT_HEADER;
      if (start_next) begin
        unique case (state)
          S_BLK0:  sha_msg <= msg_buf[1023:512];
          S_WAIT0: sha_msg <= msg_buf[511:0];
          S_WAIT1: begin
            sha_msg      <= {sha_hash, 1'b1, 191'd0, 64'h100};
            sha_blk_type <= BT_HASH;
          end
          default: sha_msg <= sha_msg;
        endcase
      end
      if (to_result) begin
        result_valid <= 1'b1;
        result_found <= res_found;
        result_nonce <= nonce;
        result_hash  <= res_abort ? '0 : digest;
      end else if (state == S_RESULT && result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

  // Job context, padded message and digest capture
  always_ff @(posedge CLK) begin
    if (accept) begin
      hdr_hi    <= job_header[639:NONCE_W];
      nonce     <= job_nonce_lo;
      nonce_hi  <= job_nonce_hi;
      stride    <= fix_stride(job_stride);
      zero_bits <= clamp_zero_bits(job_zero_bits);
    end else if (state == S_CHECK && state_next == S_PAD) begin
      nonce <= next_nonce[NONCE_W-1:0];
    end
    if (state == S_PAD) msg_buf <= {hdr_hi, nonce, 1'b1, 319'd0, 64'h280};
    if (state == S_WAIT2 && sha_blk_done) digest <= sha_hash;
  end

`ifdef NSE_HASH_CNT_EN
  function automatic logic [63:0] sat_inc64(input logic [63:0] c);
    return (&c) ? c : c + 64'd1;
  endfunction

  logic [63:0] hash_cnt_q;

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      hash_cnt_q <= '0;
    end else if (accept) begin
      hash_cnt_q <= '0;
    end else if (state == S_WAIT2 && sha_blk_done && !abort) begin
      hash_cnt_q <= sat_inc64(hash_cnt_q);
    end
  end

  assign hash_cnt = hash_cnt_q;
`else
  assign hash_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_nonce_search_engine.sv
// tb_nonce_search_engine
//   Drives jobs into nonce_search_engine with a behavioural stand-in for the
//   SHA256 core (64-cycle latency per block, chaining for HEADER blocks).
//   Expected results come from a job-level reference model and are queued
//   at submission; a monitor pops and compares whenever a result appears.
module tb_nonce_search_engine;

  localparam int NW = 32;
  localparam logic [31:0]  FORCE_NONCE = 32'd7;
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  logic          CLK = 1'b0;
  logic          nreset = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [639:0]  job_header = '0;
  logic [NW-1:0] job_nonce_lo = '0;
  logic [NW-1:0] job_nonce_hi = '0;
  logic [7:0]    job_stride = '0;
  logic [8:0]    job_zero_bits = '0;
  logic          abort = 1'b0;
  logic          sha_start;
  logic [511:0]  sha_msg;
  logic [1:0]    sha_blk_type;
  logic [255:0]  sha_hash;
  logic          sha_blk_done;
  logic          busy;
  logic          result_valid;
  logic          result_found;
  logic [NW-1:0] result_nonce;
  logic [255:0]  result_hash;
  logic          result_ack = 1'b0;
  logic [63:0]   hash_cnt;

  always #5 CLK = ~CLK;

  nonce_search_engine #(.NONCE_W(NW), .STRIDE_W(8), .ZB_W(9)) dut (
    .CLK(CLK), .nreset(nreset),
    .job_valid(job_valid), .job_ready(job_ready), .job_header(job_header),
    .job_nonce_lo(job_nonce_lo), .job_nonce_hi(job_nonce_hi),
    .job_stride(job_stride), .job_zero_bits(job_zero_bits), .abort(abort),
    .sha_start(sha_start), .sha_msg(sha_msg), .sha_blk_type(sha_blk_type),
    .sha_hash(sha_hash), .sha_blk_done(sha_blk_done), .busy(busy),
    .result_valid(result_valid), .result_found(result_found),
    .result_nonce(result_nonce), .result_hash(result_hash),
    .result_ack(result_ack), .hash_cnt(hash_cnt)
  );

  typedef struct {
    logic          found;
    logic [31:0]   nonce;
    logic [255:0]  hash;
    logic          chk_hash;
    logic [63:0]   cnt;
    int            starts;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  // Stand-in compression function (not real SHA256, but every message bit
  // and every chaining bit influences the result).
  function automatic logic [255:0] mix(input logic [255:0] st, input logic [511:0] m);
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      a  = st[31:0] ^ m[(i % 16) * 32 +: 32] ^ st[159:128];
      a  = a * 32'h9E3779B1 + 32'(i);
      a  = a ^ (a >> 15);
      st = {st[223:0], st[255:224] + a};
    end
    return st;
  endfunction

  function automatic logic [255:0] ref_digest(input logic [639:0] hdr, input logic [31:0] n);
    logic [1023:0] blk;
    logic [255:0]  h;
    blk = {hdr[639:32], n, 1'b1, 319'd0, 64'd640};
    h   = mix(mix(IV, blk[1023:512]), blk[511:0]);
    h   = mix(IV, {h, 1'b1, 191'd0, 64'd256});
    if (n == FORCE_NONCE) h[255:244] = '0;
    return h;
  endfunction

  function automatic int clz(input logic [255:0] d);
    for (int i = 255; i >= 0; i--) if (d[i]) return 255 - i;
    return 256;
  endfunction

  function automatic exp_t model_job(input logic [639:0] hdr, input logic [31:0] lo,
                                     input logic [31:0] hi, input logic [7:0] st,
                                     input logic [8:0] zb);
    exp_t e;
    longint unsigned n, step;
    int need, tries;
    logic [255:0] d;
    step  = (st == 0) ? 64'd1 : 64'(st);
    need  = (zb > 9'd256) ? 256 : int'(zb);
    n     = 64'(lo);
    tries = 0;
    while (1) begin
      tries++;
      d = ref_digest(hdr, n[31:0]);
      if (clz(d) >= need) begin e.found = 1'b1; break; end
      if (n + step > 64'(hi) || n + step > 64'hFFFF_FFFF) begin e.found = 1'b0; break; end
      n += step;
    end
    e.nonce    = n[31:0];
    e.hash     = d;
    e.chk_hash = 1'b1;
    e.starts   = 3 * tries;
`ifdef NSE_HASH_CNT_EN
    e.cnt = 64'(tries);
`else
    e.cnt = '0;
`endif
    return e;
  endfunction

  // Behavioural SHA core
  logic [255:0] core_chain, core_pend;
  logic [31:0]  core_nonce;
  logic         core_second;
  int           core_cnt;

  initial begin
    sha_hash = '0;
    sha_blk_done = 1'b0;
    core_chain = '0;
    core_pend = '0;
    core_nonce = '0;
    core_second = 1'b0;
    core_cnt = 0;
    forever begin
      @(posedge CLK);
      #1;
      sha_blk_done = 1'b0;
      if (!nreset) begin
        core_cnt = 0;
        core_second = 1'b0;
      end else begin
        if (job_ready) core_second = 1'b0;
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            sha_hash = core_pend;
            sha_blk_done = 1'b1;
          end
        end
        if (sha_start) begin
          if (sha_blk_type == 2'b10) begin
            core_pend = mix(core_second ? core_chain : IV, sha_msg);
            if (core_second) core_nonce = sha_msg[415:384];
            core_chain  = core_pend;
            core_second = !core_second;
          end else begin
            core_pend = mix(IV, sha_msg);
            if (core_nonce == FORCE_NONCE) core_pend[255:244] = '0;
          end
          core_cnt = 64;
        end
      end
    end
  end

  // Monitor / scoreboard
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  initial begin
    logic prev_rv, prev_start, prev_rdy;
    logic hold_found;
    logic [31:0] hold_nonce;
    logic [255:0] hold_hash;
    logic [63:0] hold_cnt;
    int starts, viol;
    exp_t e;
    prev_rv = 1'b0; prev_start = 1'b0; prev_rdy = 1'b0;
    hold_found = 1'b0; hold_nonce = '0; hold_hash = '0; hold_cnt = '0;
    starts = 0; viol = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (!nreset) begin
        chk("reset_ctrl", 256'({job_ready, sha_start, busy, result_valid, result_found, sha_blk_type}),
            256'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11}));
        chk("reset_data", 256'({(sha_msg != '0), (result_nonce != '0), (result_hash != '0), (hash_cnt != '0)}),
            256'(0));
        starts = 0; viol = 0;
      end else begin
        if (prev_rdy && job_valid) begin starts = 0; viol = 0; end
        if (sha_start) begin
          if (prev_start) viol++;
          starts++;
        end
        if (result_ack && prev_rv)
          chk("ack_release", 256'({result_valid, job_ready, busy}), 256'({1'b0, 1'b1, 1'b0}));
        if (result_valid) begin
          if (!prev_rv) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_result", 256'(1), 256'(0));
            end else begin
              e = exp_q.pop_front();
              chk("result_found", 256'(result_found), 256'(e.found));
              chk("result_nonce", 256'(result_nonce), 256'(e.nonce));
              if (e.chk_hash) chk("result_hash", result_hash, e.hash);
              chk("hash_cnt", 256'(hash_cnt), 256'(e.cnt));
              chk("sha_start_count", 256'(starts), 256'(e.starts));
              chk("sha_start_back_to_back", 256'(viol), 256'(0));
            end
            hold_found = result_found; hold_nonce = result_nonce;
            hold_hash = result_hash; hold_cnt = hash_cnt;
          end else begin
            chk("result_hold",
                256'({result_found != hold_found, result_nonce != hold_nonce,
                      result_hash != hold_hash, hash_cnt != hold_cnt, busy, job_ready}),
                256'(0));
          end
        end
      end
      prev_rv = result_valid;
      prev_start = sha_start;
      prev_rdy = job_ready;
    end
  end

  // Stimulus
  task automatic timeout(input string what);
    $display("FAIL timeout_%s: no DUT response within bound", what);
    $fatal(1, "bench stopped");
  endtask

  task automatic submit(input logic [639:0] hdr, input logic [31:0] lo, input logic [31:0] hi,
                        input logic [7:0] st, input logic [8:0] zb, input bit use_model);
    int guard;
    if (use_model) exp_q.push_back(model_job(hdr, lo, hi, st, zb));
    @(negedge CLK);
    job_header = hdr; job_nonce_lo = lo; job_nonce_hi = hi;
    job_stride = st; job_zero_bits = zb; job_valid = 1'b1;
    guard = 0;
    while (!job_ready) begin
      @(negedge CLK);
      guard++;
      if (guard > 1000) timeout("job_ready");
    end
    @(negedge CLK);
    job_valid = 1'b0;
  endtask

  task automatic wait_result_ack(input int hold);
    int guard;
    guard = 0;
    while (!result_valid) begin
      @(negedge CLK);
      guard++;
      if (guard > 20000) timeout("result_valid");
    end
    repeat (hold) @(negedge CLK);
    result_ack = 1'b1;
    @(negedge CLK);
    result_ack = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int seen, guard;
    seen = 0; guard = 0;
    while (seen < n) begin
      @(negedge CLK);
      if (sha_start) seen++;
      guard++;
      if (guard > 5000) timeout("sha_start");
    end
  endtask

  initial begin
    logic [639:0] hdr;
    logic [31:0] lo, hi;
    logic [7:0] st;
    logic [8:0] zb;
    exp_t ab;
    for (int w = 0; w < 20; w++) hdr[w * 32 +: 32] = $urandom;

    repeat (3) @(negedge CLK);
    nreset = 1'b1;
    @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;

    submit(hdr, 32'd5, 32'd100, 8'd3, 9'd0, 1'b1);
    wait_result_ack(3);
    submit(hdr, 32'd10, 32'd15, 8'd2, 9'd256, 1'b1);
    wait_result_ack(2);
    submit(hdr, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 8'd4, 9'd256, 1'b1);
    wait_result_ack(1);
    submit(hdr, 32'd0, 32'd20, 8'd1, 9'd12, 1'b1);
    wait_result_ack(2);
    submit(hdr, 32'd3, 32'd5, 8'd0, 9'd256, 1'b1);
    wait_result_ack(0);
    submit(hdr, 32'd50, 32'd40, 8'd1, 9'd256, 1'b1);
    wait_result_ack(1);
    submit(hdr, 32'd0, 32'd2, 8'd1, 9'd300, 1'b1);
    wait_result_ack(1);

    // Abort ten cycles into the second header block.
    ab.found = 1'b0; ab.nonce = 32'd0; ab.hash = '0; ab.chk_hash = 1'b0;
    ab.cnt = '0; ab.starts = 2;
    exp_q.push_back(ab);
    submit(hdr, 32'd0, 32'd1000, 8'd1, 9'd256, 1'b0);
    wait_starts(2);
    repeat (10) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    wait_result_ack(6);

    // Reset during the final hash block, then resubmit.
    submit(hdr, 32'd100, 32'd200, 8'd1, 9'd256, 1'b0);
    wait_starts(3);
    repeat (10) @(negedge CLK);
    nreset = 1'b0;
    repeat (3) @(negedge CLK);
    nreset = 1'b1;
    submit(hdr, 32'd100, 32'd102, 8'd1, 9'd256, 1'b1);
    wait_result_ack(2);

    for (int j = 0; j < 12; j++) begin
      for (int w = 0; w < 20; w++) hdr[w * 32 +: 32] = $urandom;
      lo = (j % 4 == 3) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      hi = lo + 32'($urandom_range(0, 8));
      if (j % 5 == 4) hi = lo - 32'd1;
      st = 8'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0:       zb = 9'($urandom_range(0, 3));
        1:       zb = 9'($urandom_range(4, 7));
        2:       zb = 9'd256;
        default: zb = 9'($urandom_range(257, 511));
      endcase
      submit(hdr, lo, hi, st, zb, 1'b1);
      wait_result_ack($urandom_range(0, 4));
    end

    repeat (4) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
